// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: drives an HD44780-style 2x16 character LCD in 4-bit mode.
// Power-up wait, init nibbles, config bytes, then an endless refresh of both
// lines from a 32-character snapshot of strdata. All pins are registered.
module lcd_refresh_ctrl #(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_INIT  = 205000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_E     = 12,
    parameter int unsigned T_GAP   = 50,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic         CCLK,
    input  logic         reset,
    input  logic [255:0] strdata,
    output logic         LCDE,
    output logic         LCDRS,
    output logic         LCDRW,
    output logic [3:0]   LCDDAT,
    output logic         ready,
    output logic         frame_done
);

    // Terminal counts: a state lasting N cycles ends when the counter reads N-1.
    localparam logic [19:0] PWR_LAST   = 20'(T_PWR - 32'd1);
    localparam logic [19:0] INIT_LAST  = 20'(T_INIT - 32'd1);
    localparam logic [19:0] SETUP_LAST = 20'(T_SETUP - 32'd1);
    localparam logic [19:0] E_LAST     = 20'(T_E - 32'd1);
    localparam logic [19:0] GAP_LAST   = 20'(T_GAP - 32'd1);
    localparam logic [19:0] CMD_LAST   = 20'(T_CMD - 32'd1);
    localparam logic [19:0] CLR_LAST   = 20'(T_CLR - 32'd1);

    typedef enum logic [2:0] {
        M_PWR   = 3'd0,
        M_INIT  = 3'd1,
        M_CFG   = 3'd2,
        M_FRAME = 3'd3,
        M_DONE  = 3'd4
    } main_t;

    typedef enum logic [1:0] {
        P_SETUP = 2'd0,
        P_EHI   = 2'd1,
        P_GAP   = 2'd2,
        P_WAIT  = 2'd3
    } phase_t;

    main_t          main_q, main_d;
    phase_t         phase_q, phase_d;
    logic [5:0]     idx_q, idx_d;
    logic           hi_q, hi_d;
    logic [19:0]    cnt_q, cnt_d;
    logic [255:0]   snap_q, snap_d;
    logic           lcde_q, lcde_d;
    logic           rs_q, rs_d;
    logic [3:0]     dat_q, dat_d;
    logic           ready_q, ready_d;
    logic           fdone_q, fdone_d;
    logic [8:0]     item_cur_s;
    logic [8:0]     item_nxt_s;
    logic [19:0]    wait_last_s;

    // Item to write in a given phase/index as {RS, byte}. Init nibbles sit in
    // the high half of the byte because only the high nibble is sent.
    function automatic logic [8:0] item_f(input main_t st, input logic [5:0] idx,
                                          input logic [255:0] snap);
        logic [255:0] sh;
        logic [4:0]   k;
        sh = 256'd0;
        k  = 5'd0;
        case (st)
            M_INIT: begin
                if (idx == 6'd3) item_f = 9'h020;
                else             item_f = 9'h030;
            end
            M_CFG: begin
                case (idx[1:0])
                    2'd0:    item_f = 9'h028;
                    2'd1:    item_f = 9'h006;
                    2'd2:    item_f = 9'h00C;
                    default: item_f = 9'h001;
                endcase
            end
            M_FRAME: begin
                if (idx == 6'd0) begin
                    item_f = 9'h080;
                end else if (idx == 6'd17) begin
                    item_f = 9'h0C0;
                end else begin
                    if (idx < 6'd17) k = 5'(idx - 6'd1);
                    else             k = 5'(idx - 6'd2);
                    sh = snap << {k, 3'b000};
                    item_f = {1'b1, sh[255:248]};
                end
            end
            default: item_f = 9'h000;
        endcase
    endfunction

    // State register: sequencer state, counters, snapshot and registered pins.
    always_ff @(posedge CCLK) begin
        if (reset) begin
            main_q  <= M_PWR;
            phase_q <= P_SETUP;
            idx_q   <= 6'd0;
            hi_q    <= 1'b0;
            cnt_q   <= 20'd0;
            snap_q  <= 256'd0;
            lcde_q  <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= 4'd0;
            ready_q <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            main_q  <= main_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            lcde_q  <= lcde_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            ready_q <= ready_d;
            fdone_q <= fdone_d;
        end
    end

    // Wait length after the current item: the clear command needs the long wait.
    always_comb begin
        item_cur_s = item_f(main_q, idx_q, snap_q);
        if (main_q == M_INIT)            wait_last_s = INIT_LAST;
        else if (item_cur_s == 9'h001)   wait_last_s = CLR_LAST;
        else                             wait_last_s = CMD_LAST;
    end

    // Next-state logic: main phase, nibble sub-phase, item index and counter.
    always_comb begin
        main_d  = main_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q + 20'd1;
        case (main_q)
            M_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    main_d  = M_INIT;
                    phase_d = P_SETUP;
                    idx_d   = 6'd0;
                    hi_d    = 1'b1;
                    cnt_d   = 20'd0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            M_INIT, M_CFG, M_FRAME: begin
                case (phase_q)
                    P_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            phase_d = P_EHI;
                            cnt_d   = 20'd0;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    P_EHI: begin
                        if (cnt_q == E_LAST) begin
                            phase_d = P_GAP;
                            cnt_d   = 20'd0;
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    P_GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_d = 20'd0;
                            if (hi_q && (main_q != M_INIT)) begin
                                phase_d = P_SETUP;
                                hi_d    = 1'b0;
                            end else begin
                                phase_d = P_WAIT;
                            end
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    P_WAIT: begin
                        if (cnt_q == wait_last_s) begin
                            cnt_d   = 20'd0;
                            phase_d = P_SETUP;
                            hi_d    = 1'b1;
                            if ((main_q == M_INIT) && (idx_q == 6'd3)) begin
                                main_d = M_CFG;
                                idx_d  = 6'd0;
                            end else if ((main_q == M_CFG) && (idx_q == 6'd3)) begin
                                main_d = M_FRAME;
                                idx_d  = 6'd0;
                            end else if ((main_q == M_FRAME) && (idx_q == 6'd33)) begin
                                main_d = M_DONE;
                                idx_d  = 6'd0;
                            end else begin
                                idx_d = idx_q + 6'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                    default: begin
                        phase_d = P_SETUP;
                        cnt_d   = 20'd0;
                    end
                endcase
            end
            M_DONE: begin
                main_d  = M_FRAME;
                phase_d = P_SETUP;
                idx_d   = 6'd0;
                hi_d    = 1'b1;
                cnt_d   = 20'd0;
            end
            default: begin
                main_d  = M_PWR;
                phase_d = P_SETUP;
                idx_d   = 6'd0;
                hi_d    = 1'b0;
                cnt_d   = 20'd0;
            end
        endcase
        // Text is captured once per frame, on entry to the frame sequence.
        if ((main_d == M_FRAME) && (main_q != M_FRAME)) snap_d = strdata;
        else                                            snap_d = snap_q;
    end

    // Output logic: pins follow the next state so they are registered in step
    // with it; RS/DAT are only updated outside the E-high phase.
    always_comb begin
        item_nxt_s = item_f(main_d, idx_d, snap_d);
        lcde_d     = 1'b0;
        rs_d       = rs_q;
        dat_d      = dat_q;
        if (((main_d == M_INIT) || (main_d == M_CFG) || (main_d == M_FRAME)) &&
            (phase_d != P_WAIT)) begin
            lcde_d = (phase_d == P_EHI);
            rs_d   = item_nxt_s[8];
            if (hi_d) dat_d = item_nxt_s[7:4];
            else      dat_d = item_nxt_s[3:0];
        end else begin
            lcde_d = 1'b0;
        end
        fdone_d = (main_d == M_DONE);
        ready_d = ready_q | (main_d == M_FRAME);
    end

    assign LCDE       = lcde_q;
    assign LCDRS      = rs_q;
    assign LCDRW      = 1'b0;
    assign LCDDAT     = dat_q;
    assign ready      = ready_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with shortened timing parameters.
module tb_lcd_refresh_ctrl;

    logic         CCLK = 1'b0;
    logic         reset;
    logic [255:0] strdata;
    logic         LCDE, LCDRS, LCDRW, ready, frame_done;
    logic [3:0]   LCDDAT;

    int checks = 0;
    int errors = 0;

    logic [4:0] nib_log[$];
    int         fd_log[$];
    logic       prev_e;
    logic [4:0] prev_rd;
    int         hi_cnt;

    // Hand-decoded ASCII of "HELLO WORLD     " and "PIPELINE CPU OK ".
    logic [7:0] exp_text [32] = '{
        8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57, 8'h4F,
        8'h52, 8'h4C, 8'h44, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
        8'h50, 8'h49, 8'h50, 8'h45, 8'h4C, 8'h49, 8'h4E, 8'h45,
        8'h20, 8'h43, 8'h50, 8'h55, 8'h20, 8'h4F, 8'h4B, 8'h20};
    // Init + config nibbles as {RS, DAT}.
    logic [4:0] exp_init [12] = '{
        5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
        5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};

    lcd_refresh_ctrl #(
        .T_PWR(10), .T_INIT(6), .T_SETUP(1), .T_E(2),
        .T_GAP(2), .T_CMD(4), .T_CLR(8)
    ) dut (
        .CCLK(CCLK), .reset(reset), .strdata(strdata),
        .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT),
        .ready(ready), .frame_done(frame_done)
    );

    always #5 CCLK = ~CCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the edge; logs E rises and checks pin timing.
    task automatic step();
        logic [4:0] rd;
        @(posedge CCLK);
        #1;
        if (reset) begin
            prev_e  = 1'b0;
            prev_rd = 5'd0;
            hi_cnt  = 0;
        end else begin
            rd = {LCDRS, LCDDAT};
            if (LCDE && !prev_e) begin
                nib_log.push_back(rd);
                check_val("setup_stable", 32'(rd), 32'(prev_rd));
                check_val("rw_low", 32'(LCDRW), 32'd0);
                hi_cnt = 1;
            end else if (LCDE && prev_e) begin
                check_val("hold_while_e", 32'(rd), 32'(prev_rd));
                hi_cnt++;
            end else if (!LCDE && prev_e) begin
                check_val("e_high_len", 32'(hi_cnt), 32'd2);
            end
            if (frame_done) fd_log.push_back(nib_log.size());
            prev_rd = rd;
            prev_e  = LCDE;
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while ((nib_log.size() < n) && (k < budget)) begin
            step();
            k++;
        end
        if (nib_log.size() < n) check_val("log_timeout", 32'(nib_log.size()), 32'(n));
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while ((fd_log.size() < n) && (k < budget)) begin
            step();
            k++;
        end
        if (fd_log.size() < n) check_val("fd_timeout", 32'(fd_log.size()), 32'(n));
    endtask

    task automatic first_rise();
        int n = 0;
        while (!LCDE && (n < 100)) begin
            step();
            n++;
        end
        check_val("first_rise", 32'(n), 32'd11);
    endtask

    task automatic check_init();
        for (int i = 0; i < 12; i++) begin
            if (i < nib_log.size()) check_val("init_nib", 32'(nib_log[i]), 32'(exp_init[i]));
            else                    check_val("init_missing", 32'(i), 32'hFFFF);
        end
    endtask

    // Compare nbytes bytes of a frame starting at log index base; alt selects all-0x5A text.
    task automatic check_frame(input int base, input int nbytes, input bit alt);
        logic [8:0] e;
        logic [9:0] got;
        logic [4:0] h, l;
        for (int i = 0; i < nbytes; i++) begin
            if (i == 0)       e = 9'h080;
            else if (i == 17) e = 9'h0C0;
            else if (alt)     e = 9'h15A;
            else if (i < 17)  e = {1'b1, exp_text[i-1]};
            else              e = {1'b1, exp_text[i-2]};
            if (base + 2*i + 1 < nib_log.size()) begin
                h = nib_log[base + 2*i];
                l = nib_log[base + 2*i + 1];
                got = {h[4], l[4], h[3:0], l[3:0]};
            end else begin
                got = 10'h3FF;
            end
            check_val("frame_byte", 32'(got), 32'({e[8], e}));
        end
    endtask

    initial begin
        int n;
        prev_e  = 1'b0;
        prev_rd = 5'd0;
        hi_cnt  = 0;
        strdata = {"HELLO WORLD     ", "PIPELINE CPU OK "};
        reset   = 1'b1;
        repeat (3) step();
        check_val("rst_lcde", 32'(LCDE), 32'd0);
        check_val("rst_lcdrs", 32'(LCDRS), 32'd0);
        check_val("rst_lcdrw", 32'(LCDRW), 32'd0);
        check_val("rst_lcddat", 32'(LCDDAT), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_fdone", 32'(frame_done), 32'd0);
        reset = 1'b0;
        first_rise();

        wait_log(12, 500);
        check_init();
        n = 0;
        while (LCDE && (n < 20)) begin
            step();
            n++;
        end
        check_val("ready_before_gap", 32'(ready), 32'd0);
        n = 0;
        while (!ready && (n < 100)) begin
            step();
            n++;
        end
        check_val("ready_gap", 32'(n), 32'd10);

        // Change text after char 3 of frame 1 has been written.
        wait_log(22, 1000);
        strdata = {32{8'h5A}};
        wait_fd(1, 2000);
        check_val("fd_pos1", 32'((fd_log.size() > 0) ? fd_log[0] : -1), 32'd80);
        repeat (3) step();
        check_val("fd_once", 32'(fd_log.size()), 32'd1);
        check_frame(12, 34, 1'b0);

        // Reset during the E-high of char 9 of frame 2.
        wait_log(102, 2000);
        check_val("mid_char_e", 32'({LCDE, LCDRS}), 32'd3);
        reset = 1'b1;
        step();
        check_val("abort_lcde", 32'(LCDE), 32'd0);
        check_val("abort_ready", 32'(ready), 32'd0);
        check_frame(80, 11, 1'b1);
        step();
        step();
        nib_log.delete();
        fd_log.delete();
        reset = 1'b0;
        first_rise();
        wait_log(12, 500);
        check_init();
        wait_fd(1, 2000);
        check_val("fd_pos3", 32'((fd_log.size() > 0) ? fd_log[0] : -1), 32'd80);
        check_frame(12, 34, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
